// File: rtl/mlp_load_sequencer.sv
// mlp_load_sequencer: streams weight words into mlp_accelerator by section/row/col, then runs one inference job.
// Optional trailer checksum over the loaded words: define LOAD_CHECKSUM_EN.
module mlp_load_sequencer #(
  parameter int IN_WIDTH = 32,
  parameter int POS_DIM  = 63,
  parameter int DIR_DIM  = 27,
  parameter int L1_UNITS = 16,
  parameter int L2_UNITS = 16,
  parameter int OUT_DIM  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  input  logic                skip_load,
  input  logic                abort,
  input  logic [IN_WIDTH-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                load_mode,
  output logic [15:0]         load_addr,
  output logic [IN_WIDTH-1:0] load_data,
  output logic                load_valid,
  output logic                acc_start,
  input  logic                acc_ready,
  input  logic                acc_done,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [15:0]         word_cnt
);
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
`ifdef LOAD_CHECKSUM_EN
    CHECK,
`endif
    START,
    RUN,
    DONE
  } state_t;
  state_t state_q, state_d;
  logic [3:0] sec_q, sec_d, row_q, row_d;
  logic [7:0] col_q, col_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0] n_rows;
  logic [8:0] n_cols;
  logic col_end, row_end, last, take, in_check;
`ifdef LOAD_CHECKSUM_EN
  logic [IN_WIDTH-1:0] sum_q, sum_d;
  logic err_q, err_d;
`endif
  always_comb begin
    n_rows = sec_q == 4'd0 ? 5'(L1_UNITS) : sec_q == 4'd2 ? 5'(L2_UNITS) : sec_q == 4'd4 ? 5'(OUT_DIM) : 5'd1;
    n_cols = sec_q == 4'd0 ? 9'(POS_DIM) : (sec_q == 4'd1 || sec_q == 4'd2) ? 9'(L1_UNITS) :
             sec_q == 4'd3 ? 9'(L2_UNITS) : sec_q == 4'd4 ? 9'(L2_UNITS + DIR_DIM) : 9'(OUT_DIM);
    col_end = {1'b0, col_q} + 9'd1 == n_cols;
    row_end = {1'b0, row_q} + 5'd1 == n_rows;
    last = col_end && row_end && sec_q == 4'd5;
    take = state_q == LOAD && s_valid;
`ifdef LOAD_CHECKSUM_EN
    in_check = state_q == CHECK;
    err = err_q;
`else
    in_check = 1'b0;
    err = 1'b0;
`endif
    busy = state_q != IDLE;
    load_mode = state_q == LOAD || in_check;
    s_ready = load_mode;
    load_valid = take;
    load_data = state_q == LOAD ? s_data : '0;
    load_addr = {sec_q, row_q, col_q};
    acc_start = state_q == START;
    done = state_q == DONE;
    word_cnt = cnt_q;
  end
  always_comb begin
    state_d = state_q;
    sec_d = sec_q;
    row_d = row_q;
    col_d = col_q;
    cnt_d = cnt_q;
`ifdef LOAD_CHECKSUM_EN
    sum_d = sum_q;
    err_d = err_q;
`endif
    // The last word of section 5 rewinds the address so a later job starts clean.
    if (take) begin
      col_d = col_end ? 8'd0 : col_q + 8'd1;
      row_d = col_end ? (row_end ? 4'd0 : row_q + 4'd1) : row_q;
      sec_d = (col_end && row_end) ? (last ? 4'd0 : sec_q + 4'd1) : sec_q;
      cnt_d = cnt_q + {15'd0, ~&cnt_q};
`ifdef LOAD_CHECKSUM_EN
      sum_d = sum_q + s_data;
`endif
    end
    case (state_q)
      IDLE: if (go) begin
        state_d = skip_load ? START : LOAD;
        sec_d = '0;
        row_d = '0;
        col_d = '0;
        cnt_d = '0;
`ifdef LOAD_CHECKSUM_EN
        sum_d = '0;
        err_d = 1'b0;
`endif
      end
`ifdef LOAD_CHECKSUM_EN
      LOAD: if (take && last) state_d = CHECK;
      CHECK: if (s_valid) begin
        state_d = s_data == sum_q ? START : IDLE;
        err_d = s_data != sum_q;
      end
`else
      LOAD: if (take && last) state_d = START;
`endif
      START: if (acc_ready) state_d = RUN;
      RUN: if (acc_done) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort wins even over a final word landing this cycle; err is left alone.
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      sec_d = '0;
      row_d = '0;
      col_d = '0;
      cnt_d = '0;
`ifdef LOAD_CHECKSUM_EN
      err_d = err_q;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sec_q <= '0;
      row_q <= '0;
      col_q <= '0;
      cnt_q <= '0;
`ifdef LOAD_CHECKSUM_EN
      sum_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sec_q <= sec_d;
      row_q <= row_d;
      col_q <= col_d;
      cnt_q <= cnt_d;
`ifdef LOAD_CHECKSUM_EN
      sum_q <= sum_d;
      err_q <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_mlp_load_sequencer.sv
// tb_mlp_load_sequencer: randomized and directed jobs checked every cycle against a behavioural job model.
module tb_mlp_load_sequencer;
  localparam int POS = 63, DIR = 27, L1 = 16, L2 = 16, OUT = 4;
  localparam int TOTAL = L1 * POS + L1 + L2 * L1 + L2 + OUT * (L2 + DIR) + OUT;
`ifdef LOAD_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  logic clk = 0, rst = 1, go = 0, skip_load = 0, abort = 0, s_valid = 0, acc_ready = 0, acc_done = 0;
  logic [31:0] s_data = 0, load_data;
  logic s_ready, load_mode, load_valid, acc_start, busy, done, err;
  logic [15:0] load_addr, word_cnt;
  always #5 clk = ~clk;
  mlp_load_sequencer #(.IN_WIDTH(32), .POS_DIM(POS), .DIR_DIM(DIR), .L1_UNITS(L1), .L2_UNITS(L2), .OUT_DIM(OUT)) dut (
    .clk(clk), .rst(rst), .go(go), .skip_load(skip_load), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .load_mode(load_mode), .load_addr(load_addr), .load_data(load_data), .load_valid(load_valid),
    .acc_start(acc_start), .acc_ready(acc_ready), .acc_done(acc_done),
    .busy(busy), .done(done), .err(err), .word_cnt(word_cnt));

  int checks = 0, fails = 0, lv_cnt = 0;
  logic [15:0] exp_addr[TOTAL];
  logic [15:0] cap[TOTAL];
  int m_ph = 0, m_idx = 0;
  bit m_ok = 0, m_err = 0;
  logic [15:0] m_cnt = 0;
  logic [31:0] m_sum = 0;

  function automatic int rows_of(int s);
    return s == 0 ? L1 : s == 2 ? L2 : s == 4 ? OUT : 1;
  endfunction
  function automatic int cols_of(int s);
    return s == 0 ? POS : (s == 1 || s == 2) ? L1 : s == 3 ? L2 : s == 4 ? L2 + DIR : OUT;
  endfunction

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  initial begin
    int k = 0;
    for (int s = 0; s < 6; s++)
      for (int r = 0; r < rows_of(s); r++)
        for (int c = 0; c < cols_of(s); c++) begin
          exp_addr[k] = 16'(s * 4096 + r * 256 + c);
          k++;
        end
  end

  // Model phases: 0 idle, 1 loading, 2 trailer, 3 starting, 4 running, 5 done pulse.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("busy", busy, m_ph != 0);
      chk("load_mode", load_mode, m_ph == 1 || m_ph == 2);
      chk("s_ready", s_ready, m_ph == 1 || m_ph == 2);
      chk("load_valid", load_valid, m_ph == 1 && s_valid);
      chk("acc_start", acc_start, m_ph == 3);
      chk("done", done, m_ph == 5);
      chk("err", err, m_err);
      chk("word_cnt", word_cnt, m_cnt);
      if (m_ph == 1 && s_valid) begin
        chk("load_addr", load_addr, exp_addr[m_idx]);
        chk("load_data", load_data, s_data);
      end
    end
    if (load_valid) begin
      if (m_idx < TOTAL) cap[m_idx] = load_addr;
      lv_cnt++;
    end
    if (rst) begin
      m_ph = 0; m_idx = 0; m_cnt = 0; m_err = 0; m_sum = 0; m_ok = 1;
    end else if (abort && m_ph != 0) begin
      m_ph = 0; m_idx = 0; m_cnt = 0;
    end else begin
      case (m_ph)
        0: if (go) begin
          m_idx = 0; m_cnt = 0; m_err = 0; m_sum = 0;
          m_ph = skip_load ? 3 : 1;
        end
        1: if (s_valid) begin
          m_sum += s_data;
          if (m_cnt != 16'hFFFF) m_cnt++;
          m_idx++;
          if (m_idx == TOTAL) begin
            m_idx = 0;
            m_ph = CK ? 2 : 3;
          end
        end
        2: if (s_valid) begin
          if (s_data == m_sum) m_ph = 3;
          else begin
            m_ph = 0;
            m_err = 1;
          end
        end
        3: if (acc_ready) m_ph = 4;
        4: if (acc_done) m_ph = 5;
        default: m_ph = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: back-to-back n; mode 1: valid every other cycle; mode 2: random gaps, data and noise.
  task automatic load_words(input int mode, input int abort_at, output logic [31:0] sum);
    sum = 0;
    for (int n = 0; n < TOTAL; n++) begin
      if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) begin
        s_valid = 0;
        s_data = $urandom;
        if (mode == 2) begin
          go = 1'($urandom);
          skip_load = 1'($urandom);
          acc_done = 1'($urandom);
        end
        tick();
        go = 0; skip_load = 0; acc_done = 0;
      end
      s_valid = 1;
      s_data = mode == 2 ? $urandom : n;
      sum += s_data;
      abort = n == abort_at;
      tick();
      abort = 0;
      if (n == abort_at) begin
        s_valid = 0;
        return;
      end
    end
    s_valid = 0;
  endtask

  task automatic trailer(input logic [31:0] v);
    if (CK) begin
      s_valid = 1;
      s_data = v;
      tick();
      s_valid = 0;
    end
  endtask

  task automatic handshake(input int k, input int d);
    for (int i = 0; i < k; i++) begin
      go = 1'($urandom);
      acc_done = 1'($urandom);
      tick();
    end
    go = 0; acc_done = 0; acc_ready = 1;
    tick();
    acc_ready = 0;
    repeat (d) tick();
    acc_done = 1;
    tick();
    acc_done = 0;
    tick();
  endtask

  initial begin
    logic [31:0] sum;
    bit sk;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_load_addr", load_addr, 0);
    chk("rst_acc_start", acc_start, 0);
    rst = 0;
    tick();
    // Back-to-back load, word n = n.
    go = 1; tick(); go = 0;
    lv_cnt = 0;
    load_words(0, -1, sum);
    chk("t1_word_cnt", word_cnt, 16'd1472);
    if (CK) begin
      chk("t1_in_check", load_mode, 1);
      chk("t1_no_start_yet", acc_start, 0);
      trailer(sum);
    end
    chk("t1_acc_start", acc_start, 1);
    chk("t1_cap0", cap[0], 16'h0000);
    chk("t1_cap1", cap[1], 16'h0001);
    chk("t1_cap63", cap[63], 16'h0100);
    chk("t1_cap1008", cap[1008], 16'h1000);
    chk("t1_cap_last", cap[1471], 16'h5003);
    handshake(3, 4);
    chk("t1_lv_cnt", lv_cnt, 1472);
    // Toggling valid.
    go = 1; tick(); go = 0;
    lv_cnt = 0;
    load_words(1, -1, sum);
    trailer(sum);
    handshake(2, 2);
    chk("t2_lv_cnt", lv_cnt, 1472);
    // Skip load with delayed acc_ready.
    go = 1; skip_load = 1; tick(); go = 0; skip_load = 0;
    chk("skip_start0", acc_start, 1);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("skip_start_held", acc_start, 1);
    end
    acc_ready = 1; tick(); acc_ready = 0;
    chk("skip_start_drop", acc_start, 0);
    chk("skip_running", busy, 1);
    repeat (9) tick();
    acc_done = 1; tick(); acc_done = 0;
    chk("skip_done", done, 1);
    tick();
    chk("skip_done_pulse", done, 0);
    chk("skip_busy_low", busy, 0);
    // Abort at word 500, then a fresh job.
    go = 1; tick(); go = 0;
    load_words(0, 500, sum);
    chk("abort_busy", busy, 0);
    chk("abort_load_mode", load_mode, 0);
    chk("abort_word_cnt", word_cnt, 0);
    chk("abort_no_done", done, 0);
    tick();
    go = 1; tick(); go = 0;
    chk("restart_addr", load_addr, 16'h0000);
    chk("restart_load_mode", load_mode, 1);
    load_words(0, -1, sum);
    trailer(sum);
    handshake(1, 1);
    if (CK) begin
      go = 1; tick(); go = 0;
      load_words(2, -1, sum);
      trailer(sum + 1);
      chk("bad_err", err, 1);
      chk("bad_idle", busy, 0);
      chk("bad_no_start", acc_start, 0);
      repeat (3) tick();
      chk("bad_err_sticky", err, 1);
      go = 1; skip_load = 1; tick(); go = 0; skip_load = 0;
      chk("err_cleared", err, 0);
      handshake(2, 3);
    end
    // Randomized jobs.
    for (int j = 0; j < 3; j++) begin
      sk = $urandom_range(0, 3) == 0;
      go = 1; skip_load = sk; tick(); go = 0; skip_load = 0;
      lv_cnt = 0;
      if (!sk) begin
        load_words(2, -1, sum);
        trailer(sum);
      end
      handshake($urandom_range(0, 6), $urandom_range(0, 6));
      chk("rand_lv_cnt", lv_cnt, sk ? 0 : TOTAL);
    end
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/mlp_load_sequencer.md
Name: mlp_load_sequencer

Overview:
- Controller that sits in front of mlp_accelerator and sequences one inference job.
- Consumes a flat valid/ready stream of 32-bit weight words and drives the accelerator's load_mode/load_addr/load_data/load_valid port with section/row/column addressing.
- After loading, handshakes the accelerator's start/ready/done and reports job completion.
- A job may skip loading so resident weights are reused.

Parameters:
- IN_WIDTH, 32, weight word width.
- POS_DIM, 63, columns of section 0.
- DIR_DIM, 27, extra projection columns.
- L1_UNITS, 16, rows of section 0; columns of sections 1 and 2.
- L2_UNITS, 16, rows of section 2; columns of section 3.
- OUT_DIM, 4, rows of section 4; columns of section 5.
- Legal ranges: every row count ≤16; every column count ≤256; L2_UNITS+DIR_DIM ≤256.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- go  in  1  job request, sampled in IDLE only
- skip_load  in  1  sampled with go; 1 = bypass loading
- abort  in  1  synchronous job cancel
- s_data  in  IN_WIDTH  weight stream data
- s_valid  in  1  stream valid
- s_ready  out  1  stream ready
- load_mode  out  1  to accelerator
- load_addr  out  16  {sec[3:0], row[3:0], col[7:0]}
- load_data  out  IN_WIDTH  to accelerator
- load_valid  out  1  to accelerator
- acc_start  out  1  to accelerator start
- acc_ready  in  1  from accelerator ready
- acc_done  in  1  from accelerator done
- busy  out  1  state != IDLE
- done  out  1  one-cycle job-complete pulse
- err  out  1  sticky checksum error (optional feature)
- word_cnt  out  16  words accepted this job

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE; all outputs 0; sec/row/col/word_cnt cleared; err cleared.
- States: IDLE, LOAD, CHECK (feature only), START, RUN, DONE.
- IDLE:
  - go=1 clears word_cnt and sec/row/col, and clears err.
  - Then LOAD, or START if skip_load=1.
  - go in any other state is ignored.
- LOAD:
  - load_mode=1 and s_ready=1 every cycle.
  - load_valid=s_valid; load_data=s_data; load_addr={sec,row,col}, combinational from stream and counters (zero latency).
  - Each cycle with s_valid: col++ and word_cnt++.
  - col wraps to 0 at the section's column count, then row++.
  - row wraps to 0 at the section's row count, then sec++.
- Section shapes (rows x cols):
  - 0: L1_UNITS x POS_DIM
  - 1: 1 x L1_UNITS
  - 2: L2_UNITS x L1_UNITS
  - 3: 1 x L2_UNITS
  - 4: OUT_DIM x (L2_UNITS+DIR_DIM)
  - 5: 1 x OUT_DIM
- Defaults total 1472 words. The last word of section 5 goes to CHECK (feature) or START.
- s_valid gaps stall the counters with no address change.
- START:
  - load_mode=0; acc_start=1 held.
  - Transition to RUN on the cycle acc_ready=1 (that cycle counts as the accepted start).
- RUN: acc_start=0; wait for acc_done=1, then DONE.
- DONE: done=1 for one cycle, then IDLE.
- abort=1 in any non-IDLE state: next state IDLE, counters cleared, no done pulse, err unchanged. abort has priority over every other transition, including a final load word arriving in the same cycle; that word is written but the job is cancelled.
- acc_done arriving outside RUN is ignored.
- word_cnt saturates at 16'hFFFF.

Optional Feature:
- Macro: LOAD_CHECKSUM_EN
- Defined:
  - A 32-bit running sum (mod 2^32) of all s_data words accepted in LOAD is kept.
  - After section 5, CHECK sets s_ready=1, load_valid=0, load_mode=1, and consumes exactly one trailer word.
  - Trailer equals the sum: go to START.
  - Trailer differs: err=1 (sticky until next go), go to IDLE, no acc_start, no done.
  - The trailer is not counted in word_cnt.
- Undefined: no CHECK state; err tied 0.

Test Plan:
- Reset, then go with skip_load=0 and 1472 back-to-back words (word n = n):
  - load_addr sequence starts 0x0000, 0x0001; word 63 at 0x0100; word 1008 at 0x1000; last word 0x5003.
  - word_cnt=1472; acc_start rises the cycle after the last word.
- Same load with s_valid toggling every other cycle -> identical address/data sequence, duration doubles, no duplicate load_valid.
- go with skip_load=1, acc_ready low 5 cycles:
  - acc_start held 5 cycles, drops after the first acc_ready cycle.
  - acc_done 10 cycles later -> single-cycle done; busy low the next cycle.
- abort asserted at word 500 -> IDLE next cycle, load_mode=0, no done; a fresh go restarts at address 0x0000.
- LOAD_CHECKSUM_EN: correct trailer -> START; trailer+1 -> err=1, no acc_start; the next go clears err.
- go while busy, and acc_done while in LOAD -> both ignored; state sequence unchanged.
